// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game-state engine.
package snake_pkg;

    localparam int unsigned GRID_W_DEF = 40;
    localparam int unsigned GRID_H_DEF = 30;
    localparam int unsigned CELL_SHIFT = 4;
    localparam int unsigned X_W        = 6;
    localparam int unsigned Y_W        = 5;
    localparam int unsigned START_X    = 20;
    localparam int unsigned START_Y    = 15;

    typedef enum logic [1:0] {
        CELL_NONE = 2'b00,
        CELL_HEAD = 2'b01,
        CELL_BODY = 2'b10,
        CELL_WALL = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } coord_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-tick divider: one-cycle registered tick every TICK_DIV enabled cycles.
module snake_tick_gen #(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (cnt == CNT_W'(TICK_DIV - 1)) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/snake_body_engine.sv
// Snake segment list, movement, growth, collisions and per-pixel cell query.
// Define SNAKE_WRAP_EN to remove walls and wrap the head around the grid.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned TICK_DIV = 12_500_000,
    parameter int unsigned GRID_W   = GRID_W_DEF,
    parameter int unsigned GRID_H   = GRID_H_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   dir_btn,
    input  logic [X_W-1:0]               apple_x,
    input  logic [Y_W-1:0]               apple_y,
    input  logic [9:0]                   x_pos,
    input  logic [9:0]                   y_pos,
    output logic [1:0]                   snake,
    output logic                         apple_eaten,
    output logic                         game_over,
    output logic [$clog2(MAX_LEN+1)-1:0] length
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    coord_t seg [MAX_LEN];
    dir_t   direction;
    dir_t   last_dir;
    dir_t   req;
    logic   req_valid;
    logic   tick;
    coord_t new_head;
    coord_t q_pos;
    logic   hit_body;
    logic   collide;
    logic   eat;
    logic   q_body;
    cell_t  q_cell;

    function automatic logic is_border(input coord_t c);
        return (c.x == '0) || (c.x == X_W'(GRID_W - 1)) ||
               (c.y == '0) || (c.y == Y_W'(GRID_H - 1));
    endfunction

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (!game_over),
        .tick (tick)
    );

    // Button priority: up > down > left > right
    always_comb begin
        req_valid = |dir_btn;
        if (dir_btn[3])      req = DIR_UP;
        else if (dir_btn[2]) req = DIR_DOWN;
        else if (dir_btn[1]) req = DIR_LEFT;
        else                 req = DIR_RIGHT;
    end

    // Next head with modular wrap; with walls the head never sits on a border
    always_comb begin
        new_head = seg[0];
        case (direction)
            DIR_UP:    new_head.y = (seg[0].y == '0) ? Y_W'(GRID_H - 1) : seg[0].y - Y_W'(1);
            DIR_DOWN:  new_head.y = (seg[0].y == Y_W'(GRID_H - 1)) ? '0 : seg[0].y + Y_W'(1);
            DIR_LEFT:  new_head.x = (seg[0].x == '0) ? X_W'(GRID_W - 1) : seg[0].x - X_W'(1);
            default:   new_head.x = (seg[0].x == X_W'(GRID_W - 1)) ? '0 : seg[0].x + X_W'(1);
        endcase
    end

    // Tail cell (index length-1) is excluded since it vacates on the move
    always_comb begin
        hit_body = 1'b0;
        for (int i = 0; i < MAX_LEN - 1; i++) begin
            if (LEN_W'(i + 2) <= length && seg[i] == new_head) hit_body = 1'b1;
        end
`ifdef SNAKE_WRAP_EN
        collide = hit_body;
`else
        collide = hit_body || is_border(new_head);
`endif
        eat = (new_head.x == apple_x) && (new_head.y == apple_y);
    end

    always_comb begin
        q_cell  = CELL_NONE;
        q_pos.x = x_pos[9:4];
        q_pos.y = y_pos[8:4];
        q_body  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < length && seg[i] == q_pos) q_body = 1'b1;
        end
        if (x_pos < 10'(GRID_W << CELL_SHIFT) && y_pos < 10'(GRID_H << CELL_SHIFT)) begin
            if (seg[0] == q_pos)      q_cell = CELL_HEAD;
            else if (q_body)          q_cell = CELL_BODY;
`ifndef SNAKE_WRAP_EN
            else if (is_border(q_pos)) q_cell = CELL_WALL;
`endif
        end
    end

    // Shifting every slot keeps the old tail in slot [length] for growth
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg[i].x <= (i < 3) ? X_W'(int'(START_X) - i) : '0;
                seg[i].y <= (i < 3) ? Y_W'(START_Y) : '0;
            end
            direction   <= DIR_RIGHT;
            last_dir    <= DIR_RIGHT;
            length      <= LEN_W'(3);
            apple_eaten <= 1'b0;
            game_over   <= 1'b0;
            snake       <= CELL_NONE;
        end else begin
            apple_eaten <= 1'b0;
            snake       <= q_cell;
            if (req_valid && req != opposite(last_dir)) direction <= req;
            if (tick && !game_over) begin
                if (collide) begin
                    game_over <= 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
                    seg[0]   <= new_head;
                    last_dir <= direction;
                    if (eat) begin
                        apple_eaten <= 1'b1;
                        if (length < LEN_W'(MAX_LEN)) length <= length + LEN_W'(1);
                    end
                end
            end
        end
    end

endmodule
